// File: rtl/div_unit_if.sv
// ID/EX <-> divider handshake bundle: request/operands toward the divider,
// stall/status/result back toward the pipeline.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       div_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  // Pipeline side: issues divide requests and consumes stall/result.
  modport master (
    output start, div_mode, dividend, divisor, flush,
    input  stall, busy, done, result
  );

  // Divider side: responds to requests.
  modport slave (
    input  start, div_mode, dividend, divisor, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Holds the ID/EX register (via stall) while a divide is in flight and
// releases it in the single DONE cycle so the instruction is not reissued.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_in_s;
  logic             div_zero_s;
  logic             ovf_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] quo_step_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] quo_fin_s;
  logic [WIDTH-1:0] rem_fin_s;

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a signed operand.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? twos_neg(x) : x;
  endfunction

  // Request classification and one restoring-division step.
  assign signed_in_s = ~bus.div_mode[0];
  assign div_zero_s  = (bus.divisor == ZERO);
  assign ovf_s       = signed_in_s & (bus.dividend == MIN_NEG) & (bus.divisor == ONES);
  assign rem_sh_s    = {rem_q, quo_q[WIDTH-1]};
  assign diff_s      = rem_sh_s - {1'b0, dvs_q};
  assign quo_step_s  = {quo_q[WIDTH-2:0], ~diff_s[WIDTH]};
  assign rem_step_s  = diff_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
  assign quo_fin_s   = (~mode_q[0] & (dvd_neg_q ^ dvs_neg_q)) ? twos_neg(quo_step_s) : quo_step_s;
  assign rem_fin_s   = (~mode_q[0] & dvd_neg_q) ? twos_neg(rem_step_s) : rem_step_s;

  // Stall is combinational so the pipeline freezes in the request cycle itself.
  assign bus.stall  = bus.start & (state_q != DONE) & ~bus.flush;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      dvs_q     <= ZERO;
      quo_q     <= ZERO;
      rem_q     <= ZERO;
      result_q  <= ZERO;
      cnt_q     <= CNT_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; flush wins everywhere, DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = (div_zero_s | ovf_s) ? DONE : CALC;
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values and registered status outputs.
  always_comb begin
    mode_d    = mode_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    busy_d    = (state_d == CALC);
    done_d    = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (bus.start & ~bus.flush) begin
          mode_d    = bus.div_mode;
          dvd_neg_d = signed_in_s & bus.dividend[WIDTH-1];
          dvs_neg_d = signed_in_s & bus.divisor[WIDTH-1];
          dvs_d     = signed_in_s ? abs_val(bus.divisor) : bus.divisor;
          quo_d     = signed_in_s ? abs_val(bus.dividend) : bus.dividend;
          rem_d     = ZERO;
          cnt_d     = CNT_TOP;
          if (div_zero_s) begin
            result_d = bus.div_mode[1] ? bus.dividend : ONES;
          end else if (ovf_s) begin
            result_d = bus.div_mode[1] ? ZERO : MIN_NEG;
          end else begin
            result_d = result_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      CALC: begin
        if (~bus.flush) begin
          quo_d = quo_step_s;
          rem_d = rem_step_s;
          if (cnt_q == CNT_ZERO) begin
            cnt_d    = CNT_ZERO;
            result_d = mode_q[1] ? rem_fin_s : quo_fin_s;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider in the EX stage. It consumes the is_div/div_mode control that the ID/EX pipeline register carries.
- It drives the stall that keeps that register frozen (IDEX_write low) while a divide is in flight. It is the responder side of the ID/EX divide-stall handshake.
- Supports DIV, DIVU, REM and REMU with RISC-V special-case semantics. It uses a radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must be at least clog2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  divide request (is_div from ID/EX); held high by ID/EX while stalled.
- div_mode  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  WIDTH  rs1 operand (post-forwarding).
- divisor  input  WIDTH  rs2 operand (post-forwarding).
- flush  input  1  branch flush; aborts any operation.
- stall  output  1  combinational; 1 means hold the IF/ID and ID/EX registers.
- busy  output  1  registered; 1 while in CALC.
- done  output  1  registered; one-cycle pulse with a valid result.
- result  output  WIDTH  quotient or remainder; holds its value until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, and all internal registers cleared. Reset mid-operation abandons the operation; the next cycle is IDLE.
- States: IDLE, CALC, DONE. stall = start & (state!=DONE) & ~flush.
- IDLE with start=1 and flush=0:
  - Latch div_mode and the operand signs.
  - Signed modes (00, 10) latch the absolute values of the operands; unsigned modes latch them raw.
  - Divide by zero (divisor==0) -> DONE. Quotient = all ones; remainder = dividend (raw, as input).
  - Signed overflow (mode 00/10, dividend=0x80000000, divisor=0xFFFFFFFF) -> DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise -> CALC with counter=WIDTH-1 and remainder accumulator=0.
- CALC, each cycle:
  - Shift {rem, quo} left by 1, then trial-subtract the divisor magnitude.
  - If non-negative, keep the difference and set quo[0]=1.
  - When counter==0 -> DONE; otherwise decrement the counter.
  - Exactly WIDTH cycles in CALC.
- Entering DONE: result is registered on the IDLE->DONE or CALC->DONE transition.
  - Quotient is negated when signed and the operand signs differ.
  - Remainder is negated when signed and the dividend is negative.
  - Selection: mode[1]=0 -> quotient, mode[1]=1 -> remainder.
  - Special cases write their fixed values directly.
- DONE: done=1 and stall=0, so ID/EX advances at the end of this cycle. Next state is IDLE unconditionally; start is not sampled in DONE. This prevents re-issuing the same instruction.
- Latency, with start first seen in cycle 0:
  - Normal case: stall=1 in cycles 0..WIDTH (33 cycles); done=1 in cycle WIDTH+1 (cycle 33).
  - Special cases: stall=1 in cycle 0 only; done in cycle 1.
- Back-to-back divides: a start in the IDLE cycle right after DONE begins a new operation with zero bubble.
- Flush in any state: next state IDLE, done=0 next cycle, stall=0 in the flush cycle, result unchanged. In IDLE, flush overrides start.
- start dropping during CALC (only possible via flush or reset) is otherwise ignored; the operation completes.
- busy=1 exactly during CALC cycles.

Test Plan:
- DIVU 100/7, start held -> stall high 33 cycles, done pulse in cycle 33, result=14; REMU of the same operands -> result=2.
- DIV -20/3 -> result=0xFFFFFFFA (-6); REM -20/3 -> result=0xFFFFFFFE (-2); REM 20/-3 -> result=2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Both give done in cycle 1 and stall for 1 cycle only.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Both give done in cycle 1.
- Flush asserted at CALC cycle 10 -> IDLE next cycle, no done pulse, result keeps its previous value, stall=0 in the flush cycle. Synchronous reset mid-CALC -> IDLE with done=0 and result=0.
- Two back-to-back DIVU ops (50/5, then 81/9 asserted in the IDLE cycle after DONE) -> results 10 then 9. The first instruction is not re-executed; start held through DONE does not retrigger.
